// File: rtl/data_mem_stage.sv
`default_nettype none
//==============================================================================
// Module   : data_mem_stage
// Purpose  : Memory stage behind the single-cycle datapath. Holds a
//            word-organised data RAM with a fixed wait-state model, stalls
//            the CPU until an access completes and returns load data to the
//            MemtoReg mux. Big-endian byte lanes; byte/half/word accesses;
//            signed or unsigned sub-word loads.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
// Parameters
//   DEPTH_WORDS : number of 32-bit RAM words (power of 2)
//   WAIT_CYCLES : extra stall cycles per access (0..15)
// Ports
//   clk         : system clock, rising edge
//   reset       : asynchronous, active-high
//   MemRead     : load request
//   MemWrite    : store request
//   Size        : 00 byte, 01 half, 10 word, 11 reserved (rejected)
//   Unsigned    : zero-extend sub-word loads when 1
//   Addr        : byte address
//   WriteData   : store data (low byte/half used for sub-word stores)
//   ReadData    : registered load result, held between loads
//   Stall       : freezes PC and register-file write while high
//   AddrErr     : misaligned, reserved-size or read+write request
// Build option
//   DATA_MEM_PERF_EN : adds LoadCount, StoreCount and StallCycles outputs
//==============================================================================
module data_mem_stage #(
   parameter int DEPTH_WORDS = 256,
   parameter int WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemRead,
   input  logic        MemWrite,
   input  logic [1:0]  Size,
   input  logic        Unsigned,
   input  logic [31:0] Addr,
   input  logic [31:0] WriteData,
   output logic [31:0] ReadData,
   output logic        Stall,
   output logic        AddrErr
`ifdef DATA_MEM_PERF_EN
   ,
   output logic [31:0] LoadCount,
   output logic [31:0] StoreCount,
   output logic [31:0] StallCycles
`endif
);

   localparam int         c_IDX_W     = $clog2(DEPTH_WORDS);
   localparam int         c_AW        = c_IDX_W + 2;
   localparam logic [3:0] c_WAIT_INIT = 4'(WAIT_CYCLES);
   localparam bit         c_NO_WAIT   = (WAIT_CYCLES == 0);
   localparam logic [1:0] c_SZ_BYTE   = 2'b00;
   localparam logic [1:0] c_SZ_HALF   = 2'b01;
   localparam logic [1:0] c_SZ_WORD   = 2'b10;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t            r_state;
   logic [3:0]        r_waitCnt;
   logic [c_AW-1:0]   r_addr;
   logic [31:0]       r_wdata;
   logic [1:0]        r_size;
   logic              r_unsigned;
   logic              r_isWrite;
   logic [31:0]       r_mem [DEPTH_WORDS];

   //---------------------------------------------------------------------------
   // Request qualification (only meaningful in IDLE)
   //---------------------------------------------------------------------------
   logic w_aligned;
   logic w_reqAny;
   logic w_reqValid;
   logic w_idle;

   always_comb begin
      w_aligned = 1'b0;
      case (Size)
         c_SZ_BYTE: w_aligned = 1'b1;
         c_SZ_HALF: w_aligned = ~Addr[0];
         c_SZ_WORD: w_aligned = (Addr[1:0] == 2'b00);
         default:   w_aligned = 1'b0;
      endcase
   end

   assign w_idle     = (r_state == S_IDLE);
   assign w_reqAny   = MemRead | MemWrite;
   assign w_reqValid = (MemRead ^ MemWrite) & w_aligned;

   // Gated by reset so the CPU is released immediately when reset asserts,
   // even if the request inputs are still driven.
   assign Stall   = ~reset & ((w_idle & w_reqValid) | (r_state == S_WAIT));
   assign AddrErr = ~reset & w_idle & w_reqAny & ~w_reqValid;

   //---------------------------------------------------------------------------
   // Access source: with no wait states the access happens at the acceptance
   // edge and must use the live inputs; otherwise the latched copy is used.
   //---------------------------------------------------------------------------
   logic            w_doAccess;
   logic [c_AW-1:0] w_accAddr;
   logic [31:0]     w_accData;
   logic [1:0]      w_accSize;
   logic            w_accUns;
   logic            w_accWrite;

   assign w_doAccess = c_NO_WAIT ? (~reset & w_idle & w_reqValid)
                                 : (~reset & (r_state == S_WAIT) & (r_waitCnt == 4'd1));
   assign w_accAddr  = c_NO_WAIT ? Addr[c_AW-1:0] : r_addr;
   assign w_accData  = c_NO_WAIT ? WriteData      : r_wdata;
   assign w_accSize  = c_NO_WAIT ? Size           : r_size;
   assign w_accUns   = c_NO_WAIT ? Unsigned       : r_unsigned;
   assign w_accWrite = c_NO_WAIT ? MemWrite       : r_isWrite;

   // Upper address bits alias onto the RAM and are deliberately dropped.
   logic w_unusedAddrHi;
   assign w_unusedAddrHi = ^Addr[31:c_AW];

   logic [c_IDX_W-1:0] w_idx;
   assign w_idx = w_accAddr[c_AW-1:2];

   //---------------------------------------------------------------------------
   // Store lanes. Byte enable bit 3 covers bits 31:24 (big-endian offset 0).
   // Sub-word data is replicated across all lanes; enables pick the target.
   //---------------------------------------------------------------------------
   logic [3:0]  w_be;
   logic [31:0] w_wLanes;

   always_comb begin
      w_be     = 4'b1111;
      w_wLanes = w_accData;
      case (w_accSize)
         c_SZ_BYTE: begin
            w_be     = 4'b1000 >> w_accAddr[1:0];
            w_wLanes = {4{w_accData[7:0]}};
         end
         c_SZ_HALF: begin
            w_be     = w_accAddr[1] ? 4'b0011 : 4'b1100;
            w_wLanes = {2{w_accData[15:0]}};
         end
         default: begin
            w_be     = 4'b1111;
            w_wLanes = w_accData;
         end
      endcase
   end

   // RAM has no reset: contents survive a reset.
   always_ff @(posedge clk) begin
      if (w_doAccess && w_accWrite) begin
         for (int i = 0; i < 4; i++) begin
            if (w_be[i]) begin
               r_mem[w_idx][8*i +: 8] <= w_wLanes[8*i +: 8];
            end
         end
      end
   end

   //---------------------------------------------------------------------------
   // Load lane extraction and extension
   //---------------------------------------------------------------------------
   logic [31:0] w_rdWord;
   logic [7:0]  w_byte;
   logic [15:0] w_half;
   logic [31:0] w_loadVal;

   assign w_rdWord = r_mem[w_idx];

   always_comb begin
      w_byte = w_rdWord[31:24];
      case (w_accAddr[1:0])
         2'd0:    w_byte = w_rdWord[31:24];
         2'd1:    w_byte = w_rdWord[23:16];
         2'd2:    w_byte = w_rdWord[15:8];
         default: w_byte = w_rdWord[7:0];
      endcase
      w_half = w_accAddr[1] ? w_rdWord[15:0] : w_rdWord[31:16];
      case (w_accSize)
         c_SZ_BYTE: w_loadVal = w_accUns ? {24'h0, w_byte}  : {{24{w_byte[7]}}, w_byte};
         c_SZ_HALF: w_loadVal = w_accUns ? {16'h0, w_half}  : {{16{w_half[15]}}, w_half};
         default:   w_loadVal = w_rdWord;
      endcase
   end

   //---------------------------------------------------------------------------
   // Control FSM and registered read data
   //---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_waitCnt  <= 4'd0;
         r_addr     <= '0;
         r_wdata    <= 32'h0;
         r_size     <= 2'b00;
         r_unsigned <= 1'b0;
         r_isWrite  <= 1'b0;
         ReadData   <= 32'h0;
      end else begin
         if (w_doAccess && !w_accWrite) begin
            ReadData <= w_loadVal;
         end
         case (r_state)
            S_IDLE: begin
               if (w_reqValid) begin
                  r_addr     <= Addr[c_AW-1:0];
                  r_wdata    <= WriteData;
                  r_size     <= Size;
                  r_unsigned <= Unsigned;
                  r_isWrite  <= MemWrite;
                  if (c_NO_WAIT) begin
                     r_state <= S_DONE;
                  end else begin
                     r_state   <= S_WAIT;
                     r_waitCnt <= c_WAIT_INIT;
                  end
               end
            end
            S_WAIT: begin
               r_waitCnt <= r_waitCnt - 4'd1;
               if (r_waitCnt == 4'd1) begin
                  r_state <= S_DONE;
               end
            end
            S_DONE: begin
               // CPU advances here; inputs are ignored for this one cycle.
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

`ifdef DATA_MEM_PERF_EN
   //---------------------------------------------------------------------------
   // Performance counters (wrap modulo 2^32)
   //---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         LoadCount   <= 32'h0;
         StoreCount  <= 32'h0;
         StallCycles <= 32'h0;
      end else begin
         if (w_doAccess) begin
            if (w_accWrite) begin
               StoreCount <= StoreCount + 32'd1;
            end else begin
               LoadCount <= LoadCount + 32'd1;
            end
         end
         if (Stall) begin
            StallCycles <= StallCycles + 32'd1;
         end
      end
   end
`endif

endmodule
`default_nettype wire

// File: tb/tb_data_mem_stage.sv
`default_nettype none
//==============================================================================
// Module   : tb_data_mem_stage
// Purpose  : Self-checking bench for data_mem_stage. Two instances share the
//            stimulus: one with two wait states, one with none; useFast picks
//            which one sees requests. A byte-addressed big-endian memory
//            model produces expected load data, pushed to a scoreboard when
//            a request is driven and popped when the access completes.
// Revision : 1.0 - initial release
//==============================================================================
module tb_data_mem_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        MemRead;
   logic        MemWrite;
   logic [1:0]  Size;
   logic        Unsigned;
   logic [31:0] Addr;
   logic [31:0] WriteData;
   logic        useFast;

   logic [31:0] rdSlow, rdFast;
   logic        stSlow, stFast, aeSlow, aeFast;
   logic [31:0] curRd;
   logic        curStall, curErr;

`ifdef DATA_MEM_PERF_EN
   logic [31:0] loadCntSlow, storeCntSlow, stallCntSlow;
   logic [31:0] loadCntFast, storeCntFast, stallCntFast;
`endif

   int checks   = 0;
   int failures = 0;

   logic [7:0]  mb [2][1024];
   logic [31:0] lastRd [2];
   logic [31:0] expRdQ[$];
   int          expStallQ[$];

   always #5 clk = ~clk;

   data_mem_stage #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) dutSlow (
      .clk(clk), .reset(reset),
      .MemRead(MemRead & ~useFast), .MemWrite(MemWrite & ~useFast),
      .Size(Size), .Unsigned(Unsigned), .Addr(Addr), .WriteData(WriteData),
      .ReadData(rdSlow), .Stall(stSlow), .AddrErr(aeSlow)
`ifdef DATA_MEM_PERF_EN
      , .LoadCount(loadCntSlow), .StoreCount(storeCntSlow), .StallCycles(stallCntSlow)
`endif
   );

   data_mem_stage #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) dutFast (
      .clk(clk), .reset(reset),
      .MemRead(MemRead & useFast), .MemWrite(MemWrite & useFast),
      .Size(Size), .Unsigned(Unsigned), .Addr(Addr), .WriteData(WriteData),
      .ReadData(rdFast), .Stall(stFast), .AddrErr(aeFast)
`ifdef DATA_MEM_PERF_EN
      , .LoadCount(loadCntFast), .StoreCount(storeCntFast), .StallCycles(stallCntFast)
`endif
   );

   assign curRd    = useFast ? rdFast : rdSlow;
   assign curStall = useFast ? stFast : stSlow;
   assign curErr   = useFast ? aeFast : aeSlow;

   task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Big-endian byte model: the byte at the lowest address is the MSB.
   task automatic modelStore(input int m, input logic [31:0] a, input logic [1:0] sz,
                             input logic [31:0] d);
      logic [9:0] b;
      b = a[9:0];
      case (sz)
         2'b00: mb[m][b] = d[7:0];
         2'b01: begin
            mb[m][b]         = d[15:8];
            mb[m][b + 10'd1] = d[7:0];
         end
         default: begin
            mb[m][b]         = d[31:24];
            mb[m][b + 10'd1] = d[23:16];
            mb[m][b + 10'd2] = d[15:8];
            mb[m][b + 10'd3] = d[7:0];
         end
      endcase
   endtask

   function automatic logic [31:0] modelLoad(input int m, input logic [31:0] a,
                                             input logic [1:0] sz, input logic uns);
      logic [9:0]  b;
      logic [7:0]  by;
      logic [15:0] hw;
      b  = a[9:0];
      by = mb[m][b];
      hw = {mb[m][b], mb[m][b + 10'd1]};
      case (sz)
         2'b00:   return uns ? {24'h0, by} : {{24{by[7]}}, by};
         2'b01:   return uns ? {16'h0, hw} : {{16{hw[15]}}, hw};
         default: return {mb[m][b], mb[m][b + 10'd1], mb[m][b + 10'd2], mb[m][b + 10'd3]};
      endcase
   endfunction

   // One complete access on the selected instance; returns in the IDLE cycle
   // following DONE so the next request is accepted.
   task automatic access(input string tag, input logic wr, input logic [1:0] sz,
                         input logic uns, input logic [31:0] a, input logic [31:0] d);
      int m;
      int stalls;
      m = useFast ? 1 : 0;
      if (wr) begin
         modelStore(m, a, sz, d);
      end else begin
         lastRd[m] = modelLoad(m, a, sz, uns);
      end
      expRdQ.push_back(lastRd[m]);
      expStallQ.push_back(useFast ? 1 : 3);

      @(negedge clk);
      MemRead = ~wr; MemWrite = wr; Size = sz; Unsigned = uns; Addr = a; WriteData = d;
      #1;
      stalls = 0;
      while (curStall && stalls < 40) begin
         stalls++;
         @(posedge clk); #1;
         MemRead = 1'b0; MemWrite = 1'b0;
      end
      checkEq({tag, "/stall"}, 32'(stalls), 32'(expStallQ.pop_front()));
      checkEq({tag, "/rdata"}, curRd, expRdQ.pop_front());
      @(posedge clk); #1;
   endtask

   // Rejected request: error flagged, no stall, no access, state stays IDLE.
   task automatic errCase(input string tag, input logic rd, input logic wr,
                          input logic [1:0] sz, input logic [31:0] a);
      @(negedge clk);
      MemRead = rd; MemWrite = wr; Size = sz; Unsigned = 1'b0; Addr = a; WriteData = 32'h0;
      #1;
      checkEq({tag, "/err"},   32'(curErr),   32'd1);
      checkEq({tag, "/stall"}, 32'(curStall), 32'd0);
      @(posedge clk); #1;
      checkEq({tag, "/stallNext"}, 32'(curStall), 32'd0);
      checkEq({tag, "/rdata"},     curRd, lastRd[useFast ? 1 : 0]);
      MemRead = 1'b0; MemWrite = 1'b0;
   endtask

   task automatic pulseReset();
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      lastRd[0] = 32'h0;
      lastRd[1] = 32'h0;
   endtask

   initial begin
      reset = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; Size = 2'b10; Unsigned = 1'b0;
      Addr = 32'h0; WriteData = 32'h0; useFast = 1'b0;
      lastRd[0] = 32'h0; lastRd[1] = 32'h0;

      // Reset state, with a valid request presented while reset is held
      @(negedge clk);
      MemRead = 1'b1;
      #1;
      checkEq("rst/stall", 32'(curStall), 32'd0);
      checkEq("rst/err",   32'(curErr),   32'd0);
      checkEq("rst/rdata", curRd,         32'h0);
      @(negedge clk);
      MemRead = 1'b0;
      reset = 1'b0;

      // Two-wait-state instance
      access("sw10",   1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
      access("lw10",   1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
      access("lb11",   1'b0, 2'b00, 1'b0, 32'h11, 32'h0);
      access("lbu11",  1'b0, 2'b00, 1'b1, 32'h11, 32'h0);
      access("lh12",   1'b0, 2'b01, 1'b0, 32'h12, 32'h0);
      access("sb13",   1'b1, 2'b00, 1'b0, 32'h13, 32'hAAAAAA55);
      access("lw10b",  1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
      access("lhu10",  1'b0, 2'b01, 1'b1, 32'h10, 32'h0);
      access("sw14",   1'b1, 2'b10, 1'b0, 32'h14, 32'h01234567);
      access("sh16",   1'b1, 2'b01, 1'b0, 32'h16, 32'h1111A5C3);
      access("lw14",   1'b0, 2'b10, 1'b0, 32'h14, 32'h0);
      access("lb16",   1'b0, 2'b00, 1'b0, 32'h16, 32'h0);
      access("alias",  1'b0, 2'b10, 1'b0, 32'h410, 32'h0);

      errCase("lh21",   1'b1, 1'b0, 2'b01, 32'h21);
      errCase("rdwr",   1'b1, 1'b1, 2'b10, 32'h10);
      errCase("size11", 1'b1, 1'b0, 2'b11, 32'h10);
      errCase("lw12",   1'b1, 1'b0, 2'b10, 32'h12);
      errCase("sw11",   1'b0, 1'b1, 2'b10, 32'h11);
      access("lwAfterErr", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);

      // Zero-wait-state instance, back-to-back accesses
      useFast = 1'b1;
      access("f_sw20",  1'b1, 2'b10, 1'b0, 32'h20, 32'h0BADF00D);
      access("f_lw20",  1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
      access("f_lw20b", 1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
      access("f_lbu23", 1'b0, 2'b00, 1'b1, 32'h23, 32'h0);
      access("f_lh22",  1'b0, 2'b01, 1'b0, 32'h22, 32'h0);
      useFast = 1'b0;

      // Reset in the middle of a store drops it
      access("sw40", 1'b1, 2'b10, 1'b0, 32'h40, 32'hCAFEF00D);
      @(negedge clk);
      MemWrite = 1'b1; Size = 2'b10; Addr = 32'h40; WriteData = 32'h12345678;
      #1;
      checkEq("drop/stall0", 32'(curStall), 32'd1);
      @(posedge clk); #1;
      MemWrite = 1'b0;
      checkEq("drop/stall1", 32'(curStall), 32'd1);
      @(negedge clk);
      reset = 1'b1;
      #1;
      checkEq("drop/stallRst", 32'(curStall), 32'd0);
      checkEq("drop/rdataRst", curRd,         32'h0);
      @(negedge clk);
      reset = 1'b0;
      lastRd[0] = 32'h0; lastRd[1] = 32'h0;
      access("lw40", 1'b0, 2'b10, 1'b0, 32'h40, 32'h0);

      // Counters over two loads and one store; RAM persists across reset
      pulseReset();
      access("p_sw80", 1'b1, 2'b10, 1'b0, 32'h80, 32'h55AA33CC);
      access("p_lw80", 1'b0, 2'b10, 1'b0, 32'h80, 32'h0);
      access("p_lw10", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
`ifdef DATA_MEM_PERF_EN
      checkEq("perf/load",  loadCntSlow,  32'd2);
      checkEq("perf/store", storeCntSlow, 32'd1);
      checkEq("perf/stall", stallCntSlow, 32'd9);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/data_mem_stage.md
Name: data_mem_stage

Overview:
- Memory stage directly downstream of the single-cycle datapath: consumes ALU result (address), register read data 2 (store data), MemRead/MemWrite and access size; returns ReadData to the MemtoReg mux.
- Contains word-organised data RAM with a configurable wait-state model.
- Asserts Stall to freeze the PC flip-flop and register-file write until the access completes.
- Supports byte/halfword/word loads (signed/unsigned) and stores with big-endian byte lanes.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit RAM words (power of 2).
- WAIT_CYCLES, 2, extra stall cycles per access (0..15).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high.
- MemRead  input  1  load request.
- MemWrite  input  1  store request.
- Size  input  2  00 byte, 01 halfword, 10 word, 11 reserved (treated as misaligned).
- Unsigned  input  1  zero-extend sub-word loads when 1.
- Addr  input  32  byte address (datapath ALUOut).
- WriteData  input  32  store data (datapath WriteData).
- ReadData  output  32  load result, registered.
- Stall  output  1  hold PC/RegWrite while high.
- AddrErr  output  1  misaligned or illegal request.

Behaviour:
- Reset (async, active-high) forces:
  - state IDLE, wait counter 0, Stall=0, ReadData=0, AddrErr=0.
  - Any in-flight store is dropped.
  - RAM contents are not cleared.
- States: IDLE, WAIT, DONE.
- IDLE:
  - Request valid when exactly one of MemRead/MemWrite is 1 and the address is aligned: half needs Addr[0]=0, word needs Addr[1:0]=0, byte is always aligned.
  - Valid request:
    - Stall=1 combinationally in the same cycle.
    - Addr, WriteData, Size, Unsigned and direction are latched at the edge.
    - Next state is WAIT with counter=WAIT_CYCLES, or DONE directly when WAIT_CYCLES=0; the access is performed at that same edge in that case.
  - Misaligned request, Size=11, or MemRead&MemWrite both 1:
    - AddrErr=1 combinationally; no access; Stall=0; stay IDLE.
  - No request: Stall=0, AddrErr=0.
- WAIT:
  - Stall=1; counter decrements each cycle.
  - At the edge where counter==1, the access is performed and the next state is DONE.
  - Input changes during WAIT are ignored (latched copy is used).
- Access:
  - Word index is latched Addr[log2(DEPTH_WORDS)+1:2]; upper bits are ignored (aliasing).
  - Store writes only the selected lanes. Big-endian lanes: byte offset 0 → bits 31:24. Half offset 0 → 31:16.
  - Store data is taken from the low byte/half of WriteData.
  - Load captures the selected lane into ReadData, sign- or zero-extended per Unsigned. Words are taken unchanged.
- DONE:
  - Stall=0; ReadData valid; the CPU advances at this edge.
  - Request inputs are ignored this cycle; next state is IDLE.
  - A new request is accepted in the following cycle.
- Latency: a request accepted in cycle 0 stalls cycles 0..WAIT_CYCLES and completes in cycle WAIT_CYCLES+1; total stall = WAIT_CYCLES+1 cycles.
- ReadData holds its last load value through stores and idle cycles.

Optional Feature:
- Macro: DATA_MEM_PERF_EN.
- When defined, adds three 32-bit outputs, all reset to 0 and wrapping modulo 2^32:
  - LoadCount: +1 per completed load.
  - StoreCount: +1 per completed store.
  - StallCycles: +1 per cycle with Stall=1.
- When undefined, these ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- WAIT_CYCLES=2: sw 0xDEADBEEF at Addr 0x10, then lw 0x10 → Stall high exactly 3 cycles for each access; ReadData=0xDEADBEEF in the DONE cycle.
- After the word store: lb Addr 0x11 → ReadData=0xFFFFFFAD; lbu 0x11 → 0x000000AD; lh 0x12 → 0xFFFFBEEF.
- sb 0x55 at 0x13 over 0xDEADBEEF, then lw 0x10 → 0xDEADBE55; other lanes unchanged.
- lh at Addr 0x21, and MemRead=MemWrite=1 → AddrErr=1, Stall=0, ReadData unchanged, RAM unchanged.
- sw 0x12345678 to 0x40, reset asserted mid-WAIT → Stall/ReadData immediately 0, state IDLE; subsequent lw 0x40 returns prior contents (store dropped).
- WAIT_CYCLES=0: back-to-back lw each stall 1 cycle; DATA_MEM_PERF_EN: after 2 loads + 1 store (WAIT=2) → LoadCount=2, StoreCount=1, StallCycles=9.
